// File: rtl/gelato_inst_buffer_mw.sv
// Per-warp circular instruction FIFOs between the decoder and the warp scheduler,
// with decoder backpressure, per-warp flush and a global rdy stall.
module gelato_inst_buffer_mw #(
  parameter int WARP_NUM  = 4,
  parameter int DEPTH     = 4,
  parameter int INST_W    = 64,
  parameter int WARP_ID_W = $clog2(WARP_NUM),
  parameter int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         in_valid,
  input  logic [WARP_ID_W-1:0]         in_warp,
  input  logic [INST_W-1:0]            in_inst,
  output logic                         in_ready,
  output logic [WARP_NUM-1:0]          out_valid,
  output logic [WARP_NUM*INST_W-1:0]   out_inst,
  input  logic [WARP_NUM-1:0]          out_pop,
  input  logic [WARP_NUM-1:0]          flush,
  output logic [WARP_NUM-1:0]          full,
  output logic [WARP_NUM*CNT_W-1:0]    count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [INST_W-1:0]   mem    [WARP_NUM][DEPTH];
  logic [PTR_W-1:0]    wr_ptr [WARP_NUM];
  logic [PTR_W-1:0]    rd_ptr [WARP_NUM];
  logic [CNT_W-1:0]    cnt    [WARP_NUM];

  logic [WARP_NUM-1:0] full_int;
  logic [WARP_NUM-1:0] valid_int;
  logic [WARP_NUM-1:0] push_sel;
  logic [WARP_NUM-1:0] pop_sel;

  always_comb begin
    for (int i = 0; i < WARP_NUM; i++) begin
      full_int[i]  = (cnt[i] == CNT_W'(DEPTH));
      valid_int[i] = (cnt[i] != '0);
    end
  end

  // An out-of-range in_warp matches no warp, so it is never ready.
  always_comb begin
    in_ready = 1'b0;
    for (int i = 0; i < WARP_NUM; i++) begin
      if (in_warp == WARP_ID_W'(i)) begin
        in_ready = rdy && !full_int[i] && !flush[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < WARP_NUM; i++) begin
      push_sel[i] = in_valid && in_ready && (in_warp == WARP_ID_W'(i));
      pop_sel[i]  = rdy && out_pop[i] && valid_int[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < WARP_NUM; i++) begin
      if (push_sel[i]) begin
        mem[i][wr_ptr[i]] <= in_inst;
      end
    end
  end

  // Flush wins over a same-cycle pop of that warp; push is already blocked by in_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WARP_NUM; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
    end else begin
      for (int i = 0; i < WARP_NUM; i++) begin
        if (rdy && flush[i]) begin
          wr_ptr[i] <= '0;
          rd_ptr[i] <= '0;
          cnt[i]    <= '0;
        end else begin
          if (push_sel[i]) begin
            wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
          end
          if (pop_sel[i]) begin
            rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
          end
          case ({push_sel[i], pop_sel[i]})
            2'b10:   cnt[i] <= cnt[i] + CNT_W'(1);
            2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
            default: cnt[i] <= cnt[i];
          endcase
        end
      end
    end
  end

  always_comb begin
    out_inst  = '0;
    count     = '0;
    out_valid = valid_int;
    full      = full_int;
    for (int i = 0; i < WARP_NUM; i++) begin
      count[i*CNT_W +: CNT_W] = cnt[i];
      if (valid_int[i]) begin
        out_inst[i*INST_W +: INST_W] = mem[i][rd_ptr[i]];
      end
    end
  end

endmodule

// File: tb/tb_gelato_inst_buffer_mw.sv
// Self-checking bench for gelato_inst_buffer_mw: directed scenarios plus random
// traffic, compared against a per-warp queue model of the buffer.
module tb_gelato_inst_buffer_mw;

  localparam int WARP_NUM  = 4;
  localparam int DEPTH     = 4;
  localparam int INST_W    = 64;
  localparam int WARP_ID_W = 2;
  localparam int CNT_W     = 3;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       rdy;
  logic                       in_valid;
  logic [WARP_ID_W-1:0]       in_warp;
  logic [INST_W-1:0]          in_inst;
  logic                       in_ready;
  logic [WARP_NUM-1:0]        out_valid;
  logic [WARP_NUM*INST_W-1:0] out_inst;
  logic [WARP_NUM-1:0]        out_pop;
  logic [WARP_NUM-1:0]        flush;
  logic [WARP_NUM-1:0]        full;
  logic [WARP_NUM*CNT_W-1:0]  count;

  logic [INST_W-1:0] model [WARP_NUM][$];
  int nVec  = 0;
  int nFail = 0;

  gelato_inst_buffer_mw #(
    .WARP_NUM(WARP_NUM), .DEPTH(DEPTH), .INST_W(INST_W)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_valid(in_valid), .in_warp(in_warp), .in_inst(in_inst), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pop(out_pop),
    .flush(flush), .full(full), .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [INST_W-1:0] obs, input logic [INST_W-1:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Every visible output is derived from the queue contents of each warp.
  task automatic checkOutput();
    for (int i = 0; i < WARP_NUM; i++) begin
      int sz;
      logic [INST_W-1:0] head;
      sz   = model[i].size();
      head = (sz != 0) ? model[i][0] : '0;
      checkEq($sformatf("count[%0d]", i), INST_W'(count[i*CNT_W +: CNT_W]), INST_W'(sz));
      checkEq($sformatf("out_valid[%0d]", i), INST_W'(out_valid[i]), INST_W'(sz != 0));
      checkEq($sformatf("full[%0d]", i), INST_W'(full[i]), INST_W'(sz == DEPTH));
      checkEq($sformatf("out_inst[%0d]", i), out_inst[i*INST_W +: INST_W], head);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WARP_ID_W-1:0] w,
                               input logic [INST_W-1:0] inst, input logic [WARP_NUM-1:0] pop,
                               input logic [WARP_NUM-1:0] fl, input logic r);
    logic expReady;
    in_valid = v; in_warp = w; in_inst = inst; out_pop = pop; flush = fl; rdy = r;
    #1;
    expReady = r && (model[w].size() < DEPTH) && !fl[w];
    checkEq("in_ready", INST_W'(in_ready), INST_W'(expReady));
    for (int i = 0; i < WARP_NUM; i++) begin
      if (r && fl[i]) begin
        model[i].delete();
      end else begin
        if (r && pop[i] && model[i].size() != 0) void'(model[i].pop_front());
        if (v && expReady && w == WARP_ID_W'(i)) model[i].push_back(inst);
      end
    end
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic doReset(input int cycles);
    rst = 1'b1; in_valid = 1'b1; in_warp = 2'd1; in_inst = 64'hDEAD;
    out_pop = '1; flush = '0; rdy = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < WARP_NUM; i++) model[i].delete();
    in_valid = 1'b0; out_pop = '0;
    checkOutput();
  endtask

  task automatic push(input logic [WARP_ID_W-1:0] w, input logic [INST_W-1:0] inst);
    applyStimulus(1'b1, w, inst, '0, '0, 1'b1);
  endtask

  task automatic pop(input logic [WARP_NUM-1:0] p);
    applyStimulus(1'b0, '0, '0, p, '0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b0; in_valid = 1'b0; in_warp = '0; in_inst = '0;
    out_pop = '0; flush = '0;
    #2;
    doReset(2);

    $display("[TB] fill warp 2");
    push(2'd2, 64'h11); push(2'd2, 64'h22); push(2'd2, 64'h33); push(2'd2, 64'h44);
    applyStimulus(1'b1, 2'd2, 64'h99, '0, '0, 1'b1);
    applyStimulus(1'b0, 2'd0, 64'h0, '0, '0, 1'b1);

    $display("[TB] drain and wrap warp 2");
    pop(4'b0100); pop(4'b0100);
    push(2'd2, 64'h55); push(2'd2, 64'h66);
    repeat (4) pop(4'b0100);

    $display("[TB] simultaneous push and pop on warp 1");
    push(2'd1, 64'h1); push(2'd1, 64'h2); push(2'd1, 64'h3);
    applyStimulus(1'b1, 2'd1, 64'hAA, 4'b0010, '0, 1'b1);
    push(2'd1, 64'h4);
    applyStimulus(1'b1, 2'd1, 64'hCC, 4'b0010, '0, 1'b1);
    applyStimulus(1'b1, 2'd1, 64'hDD, 4'b0010, '0, 1'b1);

    $display("[TB] flush priority on warp 0");
    push(2'd0, 64'h7); push(2'd0, 64'h8); push(2'd0, 64'h9);
    push(2'd3, 64'h31); push(2'd3, 64'h32);
    applyStimulus(1'b1, 2'd0, 64'hBB, 4'b0001, 4'b0001, 1'b1);
    pop(4'b0000);

    $display("[TB] global stall");
    repeat (3) applyStimulus(1'b1, 2'd3, 64'hEE, 4'b1111, 4'b1111, 1'b0);
    push(2'd3, 64'h33);

    $display("[TB] underflow and multi-pop");
    applyStimulus(1'b0, 2'd0, 64'h0, '0, 4'b1111, 1'b1);
    push(2'd0, 64'hA0); push(2'd2, 64'hA2);
    pop(4'b1111); pop(4'b1111);
    push(2'd1, 64'hB1); push(2'd1, 64'hB2); push(2'd3, 64'hB3);
    pop(4'b1010); pop(4'b1010);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      logic [WARP_NUM-1:0] p, f;
      p = WARP_NUM'($urandom) & WARP_NUM'($urandom);
      f = '0;
      for (int i = 0; i < WARP_NUM; i++) f[i] = ($urandom_range(0, 15) == 0);
      applyStimulus($urandom_range(0, 3) != 0, WARP_ID_W'($urandom),
                    {$urandom, $urandom}, p, f, $urandom_range(0, 9) != 0);
    end

    $display("[TB] mid-stream reset");
    push(2'd0, 64'h5A); push(2'd2, 64'h5B);
    doReset(1);
    push(2'd2, 64'h5C);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
    $finish;
  end

endmodule

// File: doc/gelato_inst_buffer_mw.md
Name: gelato_inst_buffer_mw

Overview:
Parametrised per-warp instruction buffer that sits between the instruction decoder and the warp scheduler. It holds one circular FIFO of decoded instructions per warp. Each FIFO has a configurable depth, and the number of warps and the instruction width are also configurable. Compared with the single-entry-per-push buffer it replaces, it adds:
- explicit ready backpressure to the decoder;
- per-warp occupancy and full outputs for fetch throttling;
- per-warp flush for branch/barrier redirect;
- a global rdy stall.

Parameters:
WARP_NUM, 4, number of warps (one FIFO each); must be >=2
DEPTH, 4, entries per warp FIFO; must be a power of two, >=2
INST_W, 64, width of one decoded-instruction record in bits
WARP_ID_W, $clog2(WARP_NUM), width of the warp-index field
CNT_W, $clog2(DEPTH+1), width of each occupancy counter

Ports:
clk  in  1  clock; all state changes on its rising edge
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; when 0 no state changes (push, pop and flush all ignored)
in_valid  in  1  decoder presents an instruction
in_warp  in  WARP_ID_W  target warp of the incoming instruction
in_inst  in  INST_W  decoded instruction record
in_ready  out  1  buffer can accept in_inst for in_warp this cycle
out_valid  out  WARP_NUM  bit i: warp i FIFO non-empty
out_inst  out  WARP_NUM*INST_W  slice i: head entry of warp i (first-word-fall-through)
out_pop  in  WARP_NUM  bit i: scheduler consumes the head of warp i
flush  in  WARP_NUM  bit i: discard all entries of warp i
full  out  WARP_NUM  bit i: warp i holds DEPTH entries
count  out  WARP_NUM*CNT_W  slice i: occupancy of warp i, 0..DEPTH

Behaviour:
- Reset (rst=1 at a clk edge): all read/write pointers and counts go to 0; out_valid=0, full=0, count=0. Reset overrides rdy and all other inputs. Asserting rst mid-stream discards all contents.
- in_ready is combinational: rdy && !full[in_warp] && !flush[in_warp]. There is no same-cycle pop bypass: a full warp refuses a push even if it is popped in that cycle.
- Push: when in_valid && in_ready, write in_inst at the write pointer of warp in_warp, increment that pointer (wraps modulo DEPTH) and increment count.
- in_warp >= WARP_NUM (non-power-of-two WARP_NUM only): in_ready=0 and nothing is written.
- Pop: when out_pop[i] && out_valid[i] && rdy, advance the read pointer of warp i (wraps) and decrement count.
  - out_pop[i] while warp i is empty is ignored and causes no underflow.
  - Several warps may be popped in the same cycle.
- Push and pop to the same warp in the same cycle: both take effect and count is unchanged. This also holds at count=DEPTH-1 and at count=1.
- Flush: when flush[i] && rdy, at the next edge warp i's pointers and count go to 0.
  - Flush has priority over a push or pop of warp i in the same cycle; both are dropped.
  - Other warps are unaffected.
- Latency: an instruction pushed at edge N appears on out_valid/out_inst at N+1. A pop at edge N exposes the next entry at N+1.
- out_inst slice i is driven to 0 while out_valid[i]=0. This keeps the outputs deterministic for the checker.
- full[i] = (count[i]==DEPTH). out_valid[i] = (count[i]!=0). Both are registered-state derived, with no combinational path from in_* or out_pop.
- rdy=0: in_ready=0; push, pop and flush are ignored; outputs hold their values.
- Storage: WARP_NUM x DEPTH x INST_W registers. The pointers are log2(DEPTH) bits and wrap naturally.

Test Plan:
- Reset then fill: rst for 2 cycles; push warp 2 with 0x11, 0x22, 0x33, 0x44 (DEPTH=4) -> count[2] = 1, 2, 3, 4; full[2]=1 after the 4th edge; out_inst[2]=0x11 from the first edge onward; in_ready=0 for in_warp=2 while in_ready=1 for in_warp=0.
- Drain and wrap: from the full warp 2, pop 2 entries, push 0x55 and 0x66, then pop 4 entries -> heads observed are 0x33, 0x44, 0x55, 0x66; count ends at 0; out_valid[2]=0 and out_inst[2]=0.
- Simultaneous push and pop: warp 1 at count=3; push 0xAA and pop in the same cycle -> count stays 3; then a push to the full... (count=3 of 4) succeeds and count=4; a push+pop at count=4 -> in_ready=0, the pop happens, count=3.
- Flush priority: warp 0 holds 3 entries; assert flush[0] together with a push of 0xBB to warp 0 and out_pop[0] -> next cycle count[0]=0, out_valid[0]=0, and 0xBB is not stored; warp 3's contents are unchanged.
- Global stall: rdy=0 for 3 cycles while driving in_valid, out_pop and flush -> in_ready=0 and count/out_inst are unchanged; raising rdy resumes normal operation.
- Underflow and multi-pop: out_pop all-ones while warps 0 and 2 each have 1 entry and warps 1 and 3 are empty -> warps 0 and 2 drop to 0; warps 1 and 3 stay at 0 with no pointer movement; subsequent pushes are read back in order.
